// File: rtl/ysyx_041514_pc_gen_pkg.sv
// Shared types and constants for the fetch-PC generator.
// Holds the FSM encoding, the sequential PC step and the default reset PC.
package ysyx_041514_pc_gen_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  localparam int unsigned PC_STEP        = 4;
  localparam logic [63:0] DEF_RESET_ADDR = 64'h8000_0000;

endpackage

// File: rtl/ysyx_041514_pc_gen_if.sv
// Fetch request bus between the PC generator (master) and the icache (slave).
interface ysyx_041514_pc_gen_if #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   pc;
  logic              pred_taken;

  modport master (output req_valid, output req_addr, output pc, output pred_taken,
                  input  req_ready);
  modport slave  (input  req_valid, input  req_addr, input  pc, input  pred_taken,
                  output req_ready);
endinterface

// File: rtl/ysyx_041514_btb.sv
// Direct-mapped branch target buffer: combinational lookup, update written at the edge.
module ysyx_041514_btb #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] lkp_pc_i,
  output logic            hit_c,
  output logic [XLEN-1:0] target_c,
  input  logic            upd_valid_i,
  input  logic [XLEN-1:0] upd_pc_i,
  input  logic [XLEN-1:0] upd_target_i,
  input  logic            upd_taken_i
);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned TAG_W = ADDR_W - 2 - IDX_W;

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [TAG_W-1:0] tag_q [DEPTH];
  logic [TAG_W-1:0] tag_d [DEPTH];
  logic [XLEN-1:0]  tgt_q [DEPTH];
  logic [XLEN-1:0]  tgt_d [DEPTH];

  logic [IDX_W-1:0] lkp_idx, upd_idx;
  logic [TAG_W-1:0] lkp_tag, upd_tag;
  logic             unused_pc_bits;

  assign lkp_idx  = lkp_pc_i[2 +: IDX_W];
  assign lkp_tag  = lkp_pc_i[ADDR_W-1 -: TAG_W];
  assign upd_idx  = upd_pc_i[2 +: IDX_W];
  assign upd_tag  = upd_pc_i[ADDR_W-1 -: TAG_W];
  assign hit_c    = valid_q[lkp_idx] && (tag_q[lkp_idx] == lkp_tag);
  assign target_c = tgt_q[lkp_idx];
  assign unused_pc_bits = ^{lkp_pc_i[XLEN-1:ADDR_W], lkp_pc_i[1:0],
                            upd_pc_i[XLEN-1:ADDR_W], upd_pc_i[1:0]};

  // Taken installs the entry; not-taken only evicts an entry owned by this branch.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    if (upd_valid_i) begin
      if (upd_taken_i) begin
        valid_d[upd_idx] = 1'b1;
        tag_d[upd_idx]   = upd_tag;
        tgt_d[upd_idx]   = upd_target_i;
      end else if (tag_q[upd_idx] == upd_tag) begin
        valid_d[upd_idx] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) valid_q <= '0;
    else      valid_q <= valid_d;
  end

  always_ff @(posedge clk) begin
    tag_q <= tag_d;
    tgt_q <= tgt_d;
  end

endmodule

// File: rtl/ysyx_041514_pc_gen.sv
// Fetch-PC generator with prioritised redirect channels and a valid/ready icache request.
// Define YSYX_041514_PC_BTB_EN to add the direct-mapped BTB predictor.
module ysyx_041514_pc_gen
  import ysyx_041514_pc_gen_pkg::*;
#(
  parameter int unsigned     XLEN       = 64,
  parameter int unsigned     ADDR_W     = 32,
  parameter logic [XLEN-1:0] RESET_ADDR = XLEN'(DEF_RESET_ADDR),
  parameter int unsigned     NUM_REDIR  = 3,
  parameter int unsigned     BTB_DEPTH  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall_i,
  input  logic                      flush_i,
  input  logic [NUM_REDIR-1:0]      redir_valid_i,
  input  logic [NUM_REDIR*XLEN-1:0] redir_pc_i,
  input  logic [NUM_REDIR-1:0]      redir_plus4_i,
  ysyx_041514_pc_gen_if.master      req_if,
  input  logic                      upd_valid_i,
  input  logic [XLEN-1:0]           upd_pc_i,
  input  logic [XLEN-1:0]           upd_target_i,
  input  logic                      upd_taken_i
);
  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] next_seq, redir_tgt, btb_target;
  logic            redir_any, req_valid, hs, btb_hit;

`ifdef YSYX_041514_PC_BTB_EN
  ysyx_041514_btb #(
    .XLEN   (XLEN),
    .ADDR_W (ADDR_W),
    .DEPTH  (BTB_DEPTH)
  ) u_btb (
    .clk          (clk),
    .rst          (rst),
    .lkp_pc_i     (pc_q),
    .hit_c        (btb_hit),
    .target_c     (btb_target),
    .upd_valid_i  (upd_valid_i),
    .upd_pc_i     (upd_pc_i),
    .upd_target_i (upd_target_i),
    .upd_taken_i  (upd_taken_i)
  );
`else
  logic unused_upd;
  assign btb_hit    = 1'b0;
  assign btb_target = '0;
  assign unused_upd = ^{upd_valid_i, upd_pc_i, upd_target_i, upd_taken_i, 32'(BTB_DEPTH)};
`endif

  assign next_seq = btb_hit ? btb_target : pc_q + XLEN'(PC_STEP);
  assign req_valid = (state_q != ST_BOOT) && !stall_i;
  assign hs        = req_valid && req_if.req_ready;

  assign req_if.req_valid  = req_valid;
  assign req_if.req_addr   = pc_q[ADDR_W-1:0];
  assign req_if.pc         = pc_q;
  assign req_if.pred_taken = btb_hit && (state_q != ST_BOOT);

  // Descending scan so the lowest-index valid channel is the one that sticks.
  always_comb begin
    redir_any = 1'b0;
    redir_tgt = '0;
    for (int k = NUM_REDIR - 1; k >= 0; k--) begin
      if (redir_valid_i[k]) begin
        redir_any = 1'b1;
        redir_tgt = redir_pc_i[k*XLEN +: XLEN]
                  + (redir_plus4_i[k] ? XLEN'(PC_STEP) : XLEN'(0));
      end
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN:  if (req_valid && !req_if.req_ready) state_d = ST_WAIT;
      ST_WAIT: if (hs) state_d = ST_RUN;
      default: state_d = ST_BOOT;
    endcase
    if (hs) pc_d = next_seq;
    // Flush and redirects win over a handshake and withdraw any pending request.
    if (flush_i) begin
      pc_d    = RESET_ADDR;
      state_d = ST_RUN;
    end else if (redir_any) begin
      pc_d    = redir_tgt;
      state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_ADDR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

endmodule

// File: tb/tb_ysyx_041514_pc_gen.sv
// Self-checking bench for ysyx_041514_pc_gen: reference model plus directed literal checks.
module tb_ysyx_041514_pc_gen;
  localparam int unsigned XLEN   = 64;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned NR     = 3;
  localparam int unsigned DEPTH  = 8;
  localparam logic [63:0] RST_PC = 64'h8000_0000;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              stall_i = 1'b0;
  logic              flush_i = 1'b0;
  logic [NR-1:0]     redir_valid_i = '0;
  logic [NR-1:0]     redir_plus4_i = '0;
  logic [NR*XLEN-1:0] redir_pc_i = '0;
  logic              upd_valid_i = 1'b0;
  logic              upd_taken_i = 1'b0;
  logic [XLEN-1:0]   upd_pc_i = '0;
  logic [XLEN-1:0]   upd_target_i = '0;

  int n_tests = 0;
  int n_fail  = 0;

  ysyx_041514_pc_gen_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bus ();

  ysyx_041514_pc_gen #(
    .XLEN       (XLEN),
    .ADDR_W     (ADDR_W),
    .RESET_ADDR (RST_PC),
    .NUM_REDIR  (NR),
    .BTB_DEPTH  (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall_i),
    .flush_i       (flush_i),
    .redir_valid_i (redir_valid_i),
    .redir_pc_i    (redir_pc_i),
    .redir_plus4_i (redir_plus4_i),
    .req_if        (bus),
    .upd_valid_i   (upd_valid_i),
    .upd_pc_i      (upd_pc_i),
    .upd_target_i  (upd_target_i),
    .upd_taken_i   (upd_taken_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [63:0] m_pc;
  bit          m_booted;
`ifdef YSYX_041514_PC_BTB_EN
  bit          mb_v   [DEPTH];
  logic [26:0] mb_tag [DEPTH];
  logic [63:0] mb_tgt [DEPTH];
`endif

  function automatic bit m_hit();
`ifdef YSYX_041514_PC_BTB_EN
    return mb_v[m_pc[4:2]] && (mb_tag[m_pc[4:2]] == m_pc[31:5]);
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk or negedge rst) begin : model
    logic [63:0] nxt;
    bit          acc;
    if (!rst) begin
      m_pc     = RST_PC;
      m_booted = 1'b0;
`ifdef YSYX_041514_PC_BTB_EN
      for (int i = 0; i < DEPTH; i++) mb_v[i] = 1'b0;
`endif
    end else begin
      nxt = m_pc + 64'd4;
`ifdef YSYX_041514_PC_BTB_EN
      if (m_hit()) nxt = mb_tgt[m_pc[4:2]];
`endif
      acc = m_booted && !stall_i && bus.req_ready;
      if (flush_i) m_pc = RST_PC;
      else if (redir_valid_i != '0) begin
        for (int k = 0; k < NR; k++) begin
          if (redir_valid_i[k]) begin
            m_pc = redir_pc_i[k*XLEN +: XLEN] + (redir_plus4_i[k] ? 64'd4 : 64'd0);
            break;
          end
        end
      end else if (acc) m_pc = nxt;
      m_booted = 1'b1;
`ifdef YSYX_041514_PC_BTB_EN
      if (upd_valid_i) begin
        if (upd_taken_i) begin
          mb_v[upd_pc_i[4:2]]   = 1'b1;
          mb_tag[upd_pc_i[4:2]] = upd_pc_i[31:5];
          mb_tgt[upd_pc_i[4:2]] = upd_target_i;
        end else if (mb_tag[upd_pc_i[4:2]] == upd_pc_i[31:5]) begin
          mb_v[upd_pc_i[4:2]] = 1'b0;
        end
      end
`endif
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      check("cyc_pc",    bus.pc, m_pc);
      check("cyc_addr",  64'(bus.req_addr), 64'(m_pc[31:0]));
      check("cyc_valid", 64'(bus.req_valid), 64'(m_booted && !stall_i));
      check("cyc_pred",  64'(bus.pred_taken), 64'(m_booted && m_hit()));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_redir(input int k, input logic [63:0] pc, input bit p4);
    redir_valid_i[k]            = 1'b1;
    redir_pc_i[k*XLEN +: XLEN]  = pc;
    redir_plus4_i[k]            = p4;
  endtask

  task automatic clr_redir();
    redir_valid_i = '0;
    redir_plus4_i = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1);
  end

  initial begin
    bus.req_ready = 1'b1;
    repeat (2) cyc();
    check("rst_pc",    bus.pc, 64'h8000_0000);
    check("rst_valid", 64'(bus.req_valid), 64'd0);
    check("rst_pred",  64'(bus.pred_taken), 64'd0);

    rst = 1'b1;
    #1 check("boot_idle", 64'(bus.req_valid), 64'd0);
    cyc(); check("seq0", 64'(bus.req_addr), 64'h8000_0000);
           check("seq0_valid", 64'(bus.req_valid), 64'd1);
    cyc(); check("seq1", 64'(bus.req_addr), 64'h8000_0004);
    cyc(); check("seq2", 64'(bus.req_addr), 64'h8000_0008);

    bus.req_ready = 1'b0;
    repeat (3) begin
      cyc();
      check("wait_addr",  64'(bus.req_addr), 64'h8000_0008);
      check("wait_valid", 64'(bus.req_valid), 64'd1);
    end
    bus.req_ready = 1'b1;
    cyc(); check("wait_accept", 64'(bus.req_addr), 64'h8000_000C);

    stall_i = 1'b1;
    set_redir(2, 64'h8000_1000, 1'b0);
    #1 check("stall_valid", 64'(bus.req_valid), 64'd0);
    cyc(); clr_redir();
    check("stall_redir", bus.pc, 64'h8000_1000);
    cyc(); check("stall_hold", bus.pc, 64'h8000_1000);
    stall_i = 1'b0;
    #1 check("unstall_valid", 64'(bus.req_valid), 64'd1);
    cyc(); check("unstall_next", bus.pc, 64'h8000_1004);

    set_redir(0, 64'h8000_0100, 1'b0);
    set_redir(1, 64'h8000_0200, 1'b1);
    cyc(); check("prio_ch0", bus.pc, 64'h8000_0100);
    redir_valid_i = 3'b010;
    cyc(); check("ch1_plus4", bus.pc, 64'h8000_0204);
    clr_redir();
    flush_i = 1'b1;
    set_redir(0, 64'h8000_0100, 1'b0);
    cyc(); check("flush_wins", bus.pc, 64'h8000_0000);
    flush_i = 1'b0; clr_redir();
    cyc(); check("after_flush", bus.pc, 64'h8000_0004);

    bus.req_ready = 1'b0;
    cyc(); check("wait2_addr", 64'(bus.req_addr), 64'h8000_0004);
    set_redir(2, 64'h8000_2000, 1'b0);
    cyc(); clr_redir(); bus.req_ready = 1'b1;
    check("wait_redir", bus.pc, 64'h8000_2000);
    cyc(); check("wait_redir_next", bus.pc, 64'h8000_2004);

    set_redir(0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    cyc(); clr_redir();
    check("wrap_addr", 64'(bus.req_addr), 64'hFFFF_FFFC);
    cyc(); check("wrap_seq", bus.pc, 64'h0);
    set_redir(1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
    cyc(); clr_redir();
    check("wrap_plus4", bus.pc, 64'h0);

`ifdef YSYX_041514_PC_BTB_EN
    upd_valid_i = 1'b1; upd_taken_i = 1'b1;
    upd_pc_i = 64'h8000_0010; upd_target_i = 64'h8000_0400;
    set_redir(2, 64'h8000_0010, 1'b0);
    cyc(); clr_redir(); upd_valid_i = 1'b0;
    #1 check("btb_pred", 64'(bus.pred_taken), 64'd1);
    cyc(); check("btb_target", bus.pc, 64'h8000_0400);
    upd_valid_i = 1'b1; upd_taken_i = 1'b0;
    set_redir(2, 64'h8000_0010, 1'b0);
    cyc(); clr_redir(); upd_valid_i = 1'b0;
    #1 check("btb_evict_pred", 64'(bus.pred_taken), 64'd0);
    cyc(); check("btb_evict_seq", bus.pc, 64'h8000_0014);
`endif

    bus.req_ready = 1'b0;
    cyc(); cyc();
    #3 rst = 1'b0;
    #1;
    check("async_pc",    bus.pc, 64'h8000_0000);
    check("async_valid", 64'(bus.req_valid), 64'd0);
    check("async_pred",  64'(bus.pred_taken), 64'd0);
    cyc();
    rst = 1'b1; bus.req_ready = 1'b1;
    #1 check("reboot_idle", 64'(bus.req_valid), 64'd0);
    cyc(); check("reboot_seq0", 64'(bus.req_addr), 64'h8000_0000);
    cyc(); check("reboot_seq1", 64'(bus.req_addr), 64'h8000_0004);
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
